// File: rtl/inst_loader_pkg.sv
// rtl/inst_loader_pkg.sv - shared defaults, memory access modes and loader state encoding
package inst_loader_pkg;

    localparam int DEF_ADDR_W    = 9;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MEM_DEPTH = 512;

    // Access mode seen by the instruction memory, shared with the fetch/decode controller
    localparam logic MODE_WRITE = 1'b0;
    localparam logic MODE_READ  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERR   = 3'd4
    } load_state_t;

endpackage

// File: rtl/inst_loader_if.sv
// rtl/inst_loader_if.sv - program word stream (valid/ready/last) between source and loader
interface inst_loader_if #(
    parameter int DATA_W = 32
) ();

    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [DATA_W-1:0] in_data;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/inst_loader_checksum.sv
// rtl/inst_loader_checksum.sv - image checksum accumulator, compiled only with LOADER_CHECKSUM_EN
`ifdef LOADER_CHECKSUM_EN
module load_checksum #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [DATA_W-1:0] exp_in,
    input  logic              add_en,
    input  logic [DATA_W-1:0] add_data,
    output logic              match
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] exp_q;

    // Clear and capture the expected sum at start, then wrap-around add every accepted word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum   <= '0;
            exp_q <= '0;
        end else if (clear) begin
            sum   <= '0;
            exp_q <= exp_in;
        end else if (add_en) begin
            sum   <= sum + add_data;
        end
    end

    assign match = (sum == exp_q);

endmodule
`endif

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - streams a program image into instruction memory, gates core_en; option LOADER_CHECKSUM_EN
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    inst_loader_if.slave      ld,
    output logic              mem_w_en,
    output logic              mem_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    output logic              core_en,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W:0]   word_count
`ifdef LOADER_CHECKSUM_EN
    ,
    input  logic [DATA_W-1:0] exp_sum,
    output logic              sum_ok
`endif
);

    load_state_t       state;
    load_state_t       next_state;
    logic [ADDR_W-1:0] wr_addr;
    logic              accept;
    logic              start_ok;
    logic              base_bad;
    logic              at_top;
    logic              sum_match;

    // start is only honoured outside an active load
    assign start_ok = start && (state == ST_IDLE || state == ST_RUN || state == ST_ERR);
    assign accept   = ld.in_valid && (state == ST_LOAD);
    assign base_bad = {1'b0, base_addr} >= (ADDR_W+1)'(MEM_DEPTH);
    assign at_top   = {1'b0, wr_addr} == (ADDR_W+1)'(MEM_DEPTH - 1);

    assign ld.in_ready = (state == ST_LOAD);
    assign core_en     = (state == ST_RUN);
    assign busy        = (state == ST_LOAD) || (state == ST_FLUSH);
    assign err         = (state == ST_ERR);

`ifdef LOADER_CHECKSUM_EN
    load_checksum #(.DATA_W(DATA_W)) u_checksum (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_ok),
        .exp_in   (exp_sum),
        .add_en   (accept),
        .add_data (ld.in_data),
        .match    (sum_match)
    );
    assign sum_ok = (state == ST_RUN) && sum_match;
`else
    assign sum_match = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: load until last word or the top address, flush the final write, then run
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start_ok) begin
                    next_state = base_bad ? ST_ERR : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (ld.in_last) begin
                        next_state = ST_FLUSH;
                    end else if (at_top) begin
                        next_state = ST_ERR;
                    end
                end
            end
            ST_FLUSH: begin
                next_state = sum_match ? ST_RUN : ST_ERR;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Write port is registered one cycle behind the accept; address and count track the image
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_w_en   <= 1'b0;
            mem_mode   <= MODE_READ;
            mem_addr   <= '0;
            mem_datain <= '0;
            wr_addr    <= '0;
            word_count <= '0;
        end else begin
            mem_w_en <= accept;
            mem_mode <= accept ? MODE_WRITE : MODE_READ;
            if (start_ok) begin
                wr_addr    <= base_addr;
                word_count <= '0;
            end else if (accept) begin
                mem_addr   <= wr_addr;
                mem_datain <= ld.in_data;
                wr_addr    <= wr_addr + (ADDR_W)'(1);
                word_count <= word_count + (ADDR_W+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - directed bench with a per-cycle loader model and shadow instruction memory
module tb_inst_loader;

    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 512;

    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_FLUSH = 2;
    localparam int P_RUN   = 3;
    localparam int P_ERR   = 4;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              mem_w_en;
    logic              mem_mode;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_datain;
    logic              core_en;
    logic              busy;
    logic              err;
    logic [ADDR_W:0]   word_count;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] exp_sum;
    logic              sum_ok;
`endif

    inst_loader_if #(.DATA_W(DATA_W)) ld ();

    inst_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .ld         (ld),
        .mem_w_en   (mem_w_en),
        .mem_mode   (mem_mode),
        .mem_addr   (mem_addr),
        .mem_datain (mem_datain),
        .core_en    (core_en),
        .busy       (busy),
        .err        (err),
        .word_count (word_count)
`ifdef LOADER_CHECKSUM_EN
        ,
        .exp_sum    (exp_sum),
        .sum_ok     (sum_ok)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] shadow [0:MEM_DEPTH-1];

    int          m_phase;
    int          m_next;
    int          m_count;
    bit          m_wen;
    int          m_addr;
    logic [31:0] m_data;
    logic [31:0] m_sum;
    logic [31:0] m_exp;
    bit          m_acc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: per cycle, outputs follow from the image position and the load phase
    always @(negedge clk) begin
        if (rst) begin
            m_phase = P_IDLE;
            m_next  = 0;
            m_count = 0;
            m_wen   = 1'b0;
            m_addr  = 0;
            m_data  = '0;
            m_sum   = '0;
            m_exp   = '0;
        end else begin
            chk("in_ready", ld.in_ready, m_phase == P_LOAD);
            chk("core_en", core_en, m_phase == P_RUN);
            chk("busy", busy, (m_phase == P_LOAD) || (m_phase == P_FLUSH));
            chk("err", err, m_phase == P_ERR);
            chk("word_count", word_count, m_count);
            chk("mem_w_en", mem_w_en, m_wen);
            chk("mem_mode", mem_mode, !m_wen);
            if (m_wen) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_datain", mem_datain, m_data);
            end
`ifdef LOADER_CHECKSUM_EN
            chk("sum_ok", sum_ok, m_phase == P_RUN);
`endif
            if (mem_w_en === 1'b1 && mem_mode === 1'b0) shadow[mem_addr] = mem_datain;

            m_acc = ld.in_valid && (m_phase == P_LOAD);
            m_wen = m_acc;
            if (m_acc) begin
                m_addr = m_next;
                m_data = ld.in_data;
            end
            case (m_phase)
                P_IDLE, P_RUN, P_ERR: begin
                    if (start) begin
                        m_count = 0;
                        m_sum   = '0;
`ifdef LOADER_CHECKSUM_EN
                        m_exp   = exp_sum;
`endif
                        if (int'(base_addr) >= MEM_DEPTH) begin
                            m_phase = P_ERR;
                        end else begin
                            m_phase = P_LOAD;
                            m_next  = int'(base_addr);
                        end
                    end
                end
                P_LOAD: begin
                    if (m_acc) begin
                        m_count = m_count + 1;
                        m_sum   = m_sum + ld.in_data;
                        if (ld.in_last) m_phase = P_FLUSH;
                        else if (m_next == MEM_DEPTH - 1) m_phase = P_ERR;
                        m_next = m_next + 1;
                    end
                end
                P_FLUSH: begin
`ifdef LOADER_CHECKSUM_EN
                    m_phase = (m_sum == m_exp) ? P_RUN : P_ERR;
`else
                    m_phase = P_RUN;
`endif
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] b);
        start     = 1'b1;
        base_addr = b;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input bit last, input int gap);
        bit done;
        int n;
        for (int i = 0; i < gap; i++) tick();
        ld.in_valid = 1'b1;
        ld.in_data  = d;
        ld.in_last  = last;
        done = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            if (ld.in_ready === 1'b1) done = 1'b1;
            tick();
            n++;
        end
        chk("accept_wait", done, 1'b1);
        ld.in_valid = 1'b0;
        ld.in_last  = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " in_ready"}, ld.in_ready, 1'b0);
        chk({tag, " mem_w_en"}, mem_w_en, 1'b0);
        chk({tag, " mem_mode"}, mem_mode, 1'b1);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " mem_datain"}, mem_datain, 0);
        chk({tag, " core_en"}, core_en, 1'b0);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " err"}, err, 1'b0);
        chk({tag, " word_count"}, word_count, 0);
    endtask

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) shadow[i] = '0;
        rst         = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        ld.in_valid = 1'b0;
        ld.in_data  = '0;
        ld.in_last  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        exp_sum     = '0;
`endif
        #2;
        chk_reset_outputs("reset");
        tick();
        tick();
        rst = 1'b0;

        // 1: three-word image, back to back
        pulse_start(9'd0);
        send_word(32'h00000020, 1'b0, 0);
        send_word(32'h20010005, 1'b0, 0);
        send_word(32'h08000003, 1'b1, 0);
        chk("t1 core_en in flush", core_en, 1'b0);
        tick();
        chk("t1 core_en", core_en, 1'b1);
        chk("t1 word_count", word_count, 3);
        chk("t1 mem0", shadow[0], 32'h00000020);
        chk("t1 mem1", shadow[1], 32'h20010005);
        chk("t1 mem2", shadow[2], 32'h08000003);

        // 2: same image with idle source cycles in between
        for (int i = 0; i < 3; i++) shadow[i] = 32'hDEADBEEF;
        pulse_start(9'd0);
        send_word(32'h00000020, 1'b0, 1);
        send_word(32'h20010005, 1'b0, 1);
        send_word(32'h08000003, 1'b1, 1);
        tick();
        chk("t2 core_en", core_en, 1'b1);
        chk("t2 mem0", shadow[0], 32'h00000020);
        chk("t2 mem1", shadow[1], 32'h20010005);
        chk("t2 mem2", shadow[2], 32'h08000003);

        // 3: overflow at the top of memory
        pulse_start(9'd510);
        send_word(32'h0000000A, 1'b0, 0);
        send_word(32'h0000000B, 1'b0, 0);
        chk("t3 err", err, 1'b1);
        ld.in_valid = 1'b1;
        ld.in_data  = 32'h0000000C;
        for (int i = 0; i < 3; i++) tick();
        ld.in_valid = 1'b0;
        chk("t3 err held", err, 1'b1);
        chk("t3 core_en", core_en, 1'b0);
        chk("t3 word_count", word_count, 2);
        chk("t3 mem510", shadow[510], 32'h0000000A);
        chk("t3 mem511", shadow[511], 32'h0000000B);
        chk("t3 no wrap", shadow[0], 32'h00000020);

        // 4: reset in the middle of a load, then reload
        pulse_start(9'd100);
        send_word(32'h00000011, 1'b0, 0);
        send_word(32'h00000022, 1'b0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("t4 rst");
        chk("t4 partial mem100", shadow[100], 32'h00000011);
        tick();
        rst = 1'b0;
        pulse_start(9'd100);
        send_word(32'h00000044, 1'b0, 0);
        send_word(32'h00000055, 1'b0, 0);
        send_word(32'h00000066, 1'b0, 0);
        send_word(32'h00000077, 1'b1, 0);
        tick();
        chk("t4 core_en", core_en, 1'b1);
        chk("t4 word_count", word_count, 4);
        chk("t4 mem100", shadow[100], 32'h00000044);
        chk("t4 mem101", shadow[101], 32'h00000055);
        chk("t4 mem103", shadow[103], 32'h00000077);

        // 5: start during a load is ignored
        pulse_start(9'd200);
        send_word(32'h000000A0, 1'b0, 0);
        start     = 1'b1;
        base_addr = 9'd300;
        send_word(32'h000000A1, 1'b0, 0);
        start     = 1'b0;
        send_word(32'h000000A2, 1'b1, 0);
        tick();
        chk("t5 core_en", core_en, 1'b1);
        chk("t5 word_count", word_count, 3);
        chk("t5 mem201", shadow[201], 32'h000000A1);
        chk("t5 mem202", shadow[202], 32'h000000A2);
        chk("t5 mem300", shadow[300], 32'h00000000);

        // 7: single-word full image ending at the top address is legal
        pulse_start(9'd511);
        send_word(32'h000000FF, 1'b1, 0);
        chk("t7 busy flush", busy, 1'b1);
        tick();
        chk("t7 core_en", core_en, 1'b1);
        chk("t7 err", err, 1'b0);
        chk("t7 word_count", word_count, 1);
        chk("t7 mem511", shadow[511], 32'h000000FF);

`ifdef LOADER_CHECKSUM_EN
        // 6: checksum match and mismatch
        exp_sum = 32'd6;
        pulse_start(9'd0);
        send_word(32'd1, 1'b0, 0);
        send_word(32'd2, 1'b0, 0);
        send_word(32'd3, 1'b1, 0);
        tick();
        chk("t6 core_en", core_en, 1'b1);
        chk("t6 sum_ok", sum_ok, 1'b1);
        exp_sum = 32'd7;
        pulse_start(9'd0);
        send_word(32'd1, 1'b0, 0);
        send_word(32'd2, 1'b0, 0);
        send_word(32'd3, 1'b1, 0);
        tick();
        chk("t6 bad err", err, 1'b1);
        chk("t6 bad core_en", core_en, 1'b0);
        chk("t6 bad sum_ok", sum_ok, 1'b0);
`endif

        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
